if_id_queue: RTL and testbench

Decoupling queue between instruction fetch and decode. Accepts (PC, instruction) pairs from the fetch stage through a valid/ready handshake, holds up to DEPTH of them in order, and presents the oldest pair to decode. Absorbs decode stalls without losing fetched instructions. Supports a single-cycle flush for taken branches and jumps.

---
 rtl/if_id_queue.sv | 76 +++++++
 tb/tb_if_id_queue.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: in-order (pc, instr) queue between fetch and decode.
// Ports: Clk, reset_n, flush; fetch side in_valid/in_ready/in_pc/in_instr;
//   decode side out_valid/out_ready/out_pc/out_instr; count = occupancy.
module if_id_queue #(
    parameter int unsigned          DEPTH   = 2,
    parameter int unsigned          PC_W    = 64,
    parameter int unsigned          INSTR_W = 32,
    parameter logic [INSTR_W-1:0]   NOP     = 32'h00000013,
    localparam int unsigned         AW      = $clog2(DEPTH),
    localparam int unsigned         CW      = AW + 1
) (
    input  logic               Clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CW-1:0]      count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;

    // Handshake flags come only from the occupancy register.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;
    assign out_instr = out_valid ? mem_instr[rd_ptr] : NOP;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage has no reset; entries are only read while counted valid.
    always_ff @(posedge Clk) begin
        if (push && !flush) begin
            mem_pc[wr_ptr]    <= in_pc;
            mem_instr[wr_ptr] <= in_instr;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed vector bench for if_id_queue (DEPTH=2).
// Table of {inputs, expected post-edge outputs} plus hand sequences.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] IA  = 32'h00620167;
    localparam logic [31:0] IB  = 32'h00A30233;
    localparam logic [31:0] IC  = 32'h00000093;
    localparam logic [31:0] ID  = 32'h00108113;
    localparam logic [31:0] IE  = 32'h00210193;
    localparam logic [31:0] IF  = 32'h00318213;
    localparam logic [31:0] IG  = 32'h00420293;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [63:0] pc;
        logic [31:0] ins;
        logic        ordy;
        logic [1:0]  e_cnt;
        logic        e_ov;
        logic        e_ir;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs[$];

    if_id_queue #(
        .DEPTH(2), .PC_W(64), .INSTR_W(32), .NOP(32'h00000013)
    ) dut (
        .Clk(Clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .count(count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] c,
                           input logic ov, input logic ir,
                           input logic [63:0] pc, input logic [31:0] ins);
        chk({tag, ".count"}, 64'(count), 64'(c));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(ir));
        chk({tag, ".out_pc"}, out_pc, pc);
        chk({tag, ".out_instr"}, 64'(out_instr), 64'(ins));
    endtask

    function automatic vec_t mk(logic fl, logic iv, logic [63:0] pc,
                                logic [31:0] ins, logic ordy,
                                logic [1:0] c, logic ov, logic ir,
                                logic [63:0] epc, logic [31:0] eins);
        vec_t v;
        v.fl = fl; v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy;
        v.e_cnt = c; v.e_ov = ov; v.e_ir = ir; v.e_pc = epc;
        v.e_ins = eins;
        return v;
    endfunction

    task automatic step(input logic fl, input logic iv,
                        input logic [63:0] pc, input logic [31:0] ins,
                        input logic ordy);
        flush = fl; in_valid = iv; in_pc = pc; in_instr = ins;
        out_ready = ordy;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // Basic flow, full back-pressure, drain, empty pop.
        vecs.push_back(mk(0, 1, 64'd0, IA, 0, 2'd1, 1, 1, 64'd0, IA));
        vecs.push_back(mk(0, 1, 64'd4, IB, 0, 2'd2, 1, 0, 64'd0, IA));
        vecs.push_back(mk(0, 1, 64'd8, IC, 0, 2'd2, 1, 0, 64'd0, IA));
        vecs.push_back(mk(0, 1, 64'd8, IC, 0, 2'd2, 1, 0, 64'd0, IA));
        vecs.push_back(mk(0, 1, 64'd8, IC, 0, 2'd2, 1, 0, 64'd0, IA));
        vecs.push_back(mk(0, 1, 64'd8, IC, 1, 2'd1, 1, 1, 64'd4, IB));
        vecs.push_back(mk(0, 1, 64'd8, IC, 0, 2'd2, 1, 0, 64'd4, IB));
        vecs.push_back(mk(0, 0, 64'd0, 32'h0, 1, 2'd1, 1, 1, 64'd8, IC));
        vecs.push_back(mk(0, 0, 64'd0, 32'h0, 1, 2'd0, 0, 1, 64'd0, NOP));
        vecs.push_back(mk(0, 0, 64'd0, 32'h0, 1, 2'd0, 0, 1, 64'd0, NOP));
        // Flush beats simultaneous push and pop.
        vecs.push_back(mk(0, 1, 64'd16, ID, 0, 2'd1, 1, 1, 64'd16, ID));
        vecs.push_back(mk(1, 1, 64'd20, IE, 1, 2'd0, 0, 1, 64'd0, NOP));
        vecs.push_back(mk(0, 1, 64'd100, IF, 0, 2'd1, 1, 1, 64'd100, IF));
        // Push and pop together at count 1.
        vecs.push_back(mk(0, 1, 64'd104, IG, 1, 2'd1, 1, 1, 64'd104, IG));
        vecs.push_back(mk(0, 0, 64'd0, 32'h0, 1, 2'd0, 0, 1, 64'd0, NOP));

        // Asynchronous reset mid-cycle with one entry held.
        #7;
        reset_n = 1'b1;
        chk_all("idle", 2'd0, 0, 1, 64'd0, NOP);
        step(0, 1, 64'h40, IB, 0);
        chk_all("pre_rst", 2'd1, 1, 1, 64'h40, IB);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 2'd0, 0, 1, 64'd0, NOP);
        @(negedge Clk);
        reset_n = 1'b1;
        @(negedge Clk);

        foreach (vecs[i]) begin
            step(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ins,
                 vecs[i].ordy);
            chk_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_ov,
                    vecs[i].e_ir, vecs[i].e_pc, vecs[i].e_ins);
        end

        // Streaming: output shows the pair pushed on the previous edge.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] ins;
            ins = 32'hABCD0013 ^ 32'(i << 7);
            step(0, 1, 64'(4 * i), ins, 1);
            chk_all($sformatf("stream%0d", i), 2'd1, 1, 1,
                    64'(4 * i), ins);
        end
        step(0, 0, 64'd0, 32'h0, 1);
        chk_all("stream_drain", 2'd0, 0, 1, 64'd0, NOP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
